// File: rtl/vga_pkg.sv
// Shared timing constants, pixel type and helpers for the
// layered VGA display pipeline.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb332_t;

    typedef enum logic {
        TG_IDLE,
        TG_RUN
    } tg_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_layer_scheduler_if.sv
// Bus between the scheduler and its pixel-layer generators:
// counters out to the layers, per-layer pixels and claims back.
interface vga_layer_scheduler_if #(
    parameter int NUM_LAYERS = 4
);

    logic [9:0]              hcount;
    logic [9:0]              vcount;
    logic                    enable;
    logic                    frame_start;
    logic [3*NUM_LAYERS-1:0] layer_red;
    logic [3*NUM_LAYERS-1:0] layer_green;
    logic [2*NUM_LAYERS-1:0] layer_blue;
    logic [NUM_LAYERS-1:0]   layer_valid;

    modport master (
        output hcount, vcount, enable, frame_start,
        input  layer_red, layer_green, layer_blue, layer_valid
    );

    modport slave (
        input  hcount, vcount, enable, frame_start,
        output layer_red, layer_green, layer_blue, layer_valid
    );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters, active-area enable, raw syncs and the
// frame-start pulse for the layer pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       enable,
    output logic       frame_start,
    output logic       hsync_raw,
    output logic       vsync_raw
);

    import vga_pkg::*;

    localparam int HTOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC - 1;

    tg_state_t  state_q;
    tg_state_t  state_d;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       run;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TG_IDLE;
            hcount  <= '0;
            vcount  <= '0;
        end else begin
            state_q <= state_d;
            hcount  <= h_next;
            vcount  <= v_next;
        end
    end

    // The first clock after reset only arms the raster so that
    // (0,0) is presented, with frame_start, for one full cycle.
    always_comb begin
        state_d = state_q;
        h_next  = hcount;
        v_next  = vcount;
        run     = 1'b0;
        case (state_q)
            TG_IDLE: begin
                state_d = TG_RUN;
            end
            TG_RUN: begin
                run = 1'b1;
                if (hcount == 10'(HTOT - 1)) begin
                    h_next = '0;
                    if (vcount == 10'(VTOT - 1)) v_next = '0;
                    else                         v_next = vcount + 10'd1;
                end else begin
                    h_next = hcount + 10'd1;
                end
            end
            default: state_d = TG_IDLE;
        endcase
    end

    assign enable = run
        && (hcount < 10'(H_ACTIVE))
        && (vcount < 10'(V_ACTIVE));

    assign frame_start = run
        && (hcount == '0)
        && (vcount == '0);

    assign hsync_raw = !(run
        && (hcount >= 10'(HS_BEG))
        && (hcount <= 10'(HS_END)));

    assign vsync_raw = !(run
        && (vcount >= 10'(VS_BEG))
        && (vcount <= 10'(VS_END)));

endmodule

// File: rtl/vga_layer_scheduler.sv
// Drives the raster to all layers, aligns control with their
// registered pixels and composites the highest-priority claim.
module vga_layer_scheduler #(
    parameter int NUM_LAYERS = 4,
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int LAYER_LAT  = 1,
    localparam int LW = (NUM_LAYERS > 1)
        ? vga_pkg::clog2(NUM_LAYERS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_LAYERS-1:0] layer_en_mask,
    vga_layer_scheduler_if.master bus,
    output logic [2:0]            vga_red,
    output logic [2:0]            vga_green,
    output logic [1:0]            vga_blue,
    output logic                  vga_hsync,
    output logic                  vga_vsync,
    output logic [LW-1:0]         active_layer
);

    import vga_pkg::*;

    localparam int PW = LAYER_LAT * NUM_LAYERS;

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       enable;
    logic       frame_start;
    logic       hsync_raw;
    logic       vsync_raw;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock       (clock),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .enable      (enable),
        .frame_start (frame_start),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw)
    );

    assign bus.hcount      = hcount;
    assign bus.vcount      = vcount;
    assign bus.enable      = enable;
    assign bus.frame_start = frame_start;

    logic [NUM_LAYERS-1:0] shadow_q;
    logic [NUM_LAYERS-1:0] mask_now;
    logic [LAYER_LAT-1:0]  en_p;
    logic [LAYER_LAT-1:0]  hs_p;
    logic [LAYER_LAT-1:0]  vs_p;
    logic [LAYER_LAT-1:0][NUM_LAYERS-1:0] mask_p;

    // Pixel (0,0) already uses the mask sampled at frame_start.
    assign mask_now = frame_start ? layer_en_mask : shadow_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '1;
            en_p     <= '0;
            hs_p     <= '1;
            vs_p     <= '1;
            mask_p   <= '1;
        end else begin
            shadow_q <= mask_now;
            en_p     <= LAYER_LAT'({en_p, enable});
            hs_p     <= LAYER_LAT'({hs_p, hsync_raw});
            vs_p     <= LAYER_LAT'({vs_p, vsync_raw});
            mask_p   <= PW'({mask_p, mask_now});
        end
    end

    logic                  en_a;
    logic [NUM_LAYERS-1:0] mask_a;
    rgb332_t               pick;
    logic [LW-1:0]         win;

    assign en_a   = en_p[LAYER_LAT-1];
    assign mask_a = mask_p[LAYER_LAT-1];

    always_comb begin
        pick = '0;
        win  = '0;
        if (mask_a[0]) begin
            pick = {bus.layer_red[2:0],
                    bus.layer_green[2:0],
                    bus.layer_blue[1:0]};
        end
        for (int i = 1; i < NUM_LAYERS; i++) begin
            if (bus.layer_valid[i] && mask_a[i]) begin
                pick = {bus.layer_red[R_W*i +: R_W],
                        bus.layer_green[G_W*i +: G_W],
                        bus.layer_blue[B_W*i +: B_W]};
                win  = LW'(i);
            end
        end
        if (!en_a) begin
            pick = '0;
            win  = '0;
        end
    end

    // The background never claims; its flag is not consulted.
    logic unused_valid0;
    assign unused_valid0 = bus.layer_valid[0];

    rgb332_t       rgb_q;
    logic [LW-1:0] act_q;
    logic          hs_q;
    logic          vs_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
            act_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= pick;
            act_q <= win;
            hs_q  <= hs_p[LAYER_LAT-1];
            vs_q  <= vs_p[LAYER_LAT-1];
        end
    end

    assign vga_red      = rgb_q.r;
    assign vga_green    = rgb_q.g;
    assign vga_blue     = rgb_q.b;
    assign vga_hsync    = hs_q;
    assign vga_vsync    = vs_q;
    assign active_layer = act_q;

endmodule

// File: tb/tb_vga_layer_scheduler.sv
// Directed bench for the layer scheduler on a shrunken raster
// (25 x 15) so several whole frames fit in a short run.
module tb_vga_layer_scheduler;

    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int BOUND = 2 * FRAME;

    logic       clock;
    logic       reset_n;
    logic [3:0] mask;
    logic [2:0] vga_red;
    logic [2:0] vga_green;
    logic [1:0] vga_blue;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [1:0] active_layer;

    logic v0, v1, v3, l2_on, l2v;
    int   cyc;
    int   n_chk;
    int   n_bad;

    vga_layer_scheduler_if #(.NUM_LAYERS(4)) bus ();

    vga_layer_scheduler #(
        .NUM_LAYERS (4),
        .H_ACTIVE   (HA),
        .H_FP       (HF),
        .H_SYNC     (HS),
        .H_BP       (HB),
        .V_ACTIVE   (VA),
        .V_FP       (VF),
        .V_SYNC     (VS),
        .V_BP       (VB),
        .LAYER_LAT  (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .layer_en_mask (mask),
        .bus           (bus),
        .vga_red       (vga_red),
        .vga_green     (vga_green),
        .vga_blue      (vga_blue),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .active_layer  (active_layer)
    );

    // L3 000/000/01, L2 010/011/10, L1 100/000/00, L0 111/111/11
    assign bus.layer_red   = {3'b000, 3'b010, 3'b100, 3'b111};
    assign bus.layer_green = {3'b000, 3'b011, 3'b000, 3'b111};
    assign bus.layer_blue  = {2'b01, 2'b10, 2'b00, 2'b11};
    assign bus.layer_valid = {v3, l2v, v1, v0};

    // Layer 2 is a registered claim on column 5 only.
    always @(posedge clock) l2v <= l2_on && (bus.hcount == 10'd5);

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_sig(input int which, input logic val,
                            output int at);
        int   n;
        logic s;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clock);
            #1;
            case (which)
                0:       s = bus.frame_start;
                1:       s = vga_hsync;
                default: s = vga_vsync;
            endcase
            if (s == val) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > BOUND) begin
                    chk("wait_sig_timeout", 32'(which), 32'hffff);
                    done = 1'b1;
                end
            end
        end
        at = cyc;
    endtask

    task automatic wait_cnt(input int h, input int v);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clock);
            #1;
            if (bus.hcount == 10'(h) && bus.vcount == 10'(v)) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > BOUND) begin
                    chk("wait_cnt_timeout", 32'(h), 32'(v));
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic pix(input string tag, input int h, input int v,
                       input logic [7:0] rgb, input logic [1:0] act);
        wait_cnt(h, v);
        repeat (2) @(posedge clock);
        #1;
        chk(tag, {vga_red, vga_green, vga_blue}, rgb);
        chk({tag, "_al"}, active_layer, act);
    endtask

    int c0, c1, c2, c3, c4, c5, c6;

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        cyc     = 0;
        reset_n = 1'b0;
        mask    = 4'b1111;
        v0      = 1'b0;
        v1      = 1'b0;
        v3      = 1'b0;
        l2_on   = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_h", bus.hcount, 0);
        chk("rst_v", bus.vcount, 0);
        chk("rst_en", bus.enable, 0);
        chk("rst_fs", bus.frame_start, 0);
        chk("rst_rgb", {vga_red, vga_green, vga_blue}, 0);
        chk("rst_sync", {vga_hsync, vga_vsync}, 2'b11);
        chk("rst_al", active_layer, 0);

        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        c0 = cyc;
        chk("rel_fs", bus.frame_start, 1);
        chk("rel_hv", {bus.hcount, bus.vcount}, 0);
        chk("rel_en", bus.enable, 1);
        @(posedge clock);
        #1;
        chk("rel_h1", bus.hcount, 1);
        chk("rel_fs_off", bus.frame_start, 0);

        wait_sig(1, 1'b0, c1);
        chk("hs_start", c1 - c0, HA + HF + 2);
        wait_sig(1, 1'b1, c2);
        chk("hs_width", c2 - c1, HS);
        wait_sig(1, 1'b0, c3);
        chk("hs_period", c3 - c1, HT);
        wait_sig(2, 1'b0, c4);
        chk("vs_start", c4 - c0, (VA + VF) * HT + 2);
        wait_sig(2, 1'b1, c5);
        chk("vs_width", c5 - c4, VS * HT);
        wait_sig(0, 1'b1, c6);
        chk("fs_period", c6 - c0, FRAME);

        pix("bg_left", 0, 1, 8'hff, 2'd0);
        pix("bg_right", HA - 1, 1, 8'hff, 2'd0);
        pix("bg_hblank", HA, 1, 8'h00, 2'd0);
        pix("bg_last", HA - 1, VA - 1, 8'hff, 2'd0);
        pix("bg_vblank", 3, VA, 8'h00, 2'd0);

        v1    = 1'b1;
        v3    = 1'b1;
        l2_on = 1'b1;
        pix("l3_over_l1", 4, 2, 8'h01, 2'd3);
        pix("l3_over_l2", 5, 2, 8'h01, 2'd3);
        v3 = 1'b0;
        pix("l2_col5", 5, 3, 8'h4e, 2'd2);
        pix("l1_col6", 6, 3, 8'h80, 2'd1);
        pix("l1_col4", 4, 3, 8'h80, 2'd1);

        v3 = 1'b1;
        wait_cnt(0, VA / 2);
        mask = 4'b0111;
        pix("mask_held", 2, VA - 2, 8'h01, 2'd3);
        wait_sig(0, 1'b1, c6);
        pix("mask_new_l1", 2, 1, 8'h80, 2'd1);
        pix("mask_new_l2", 5, 1, 8'h4e, 2'd2);

        mask = 4'b0000;
        v0   = 1'b1;
        wait_sig(0, 1'b1, c6);
        pix("mask0_a", 2, 1, 8'h00, 2'd0);
        pix("mask0_b", 5, 1, 8'h00, 2'd0);
        wait_sig(1, 1'b0, c1);
        wait_sig(1, 1'b1, c2);
        chk("mask0_hs", c2 - c1, HS);

        mask = 4'b0001;
        wait_sig(0, 1'b1, c6);
        pix("bg_only_a", 2, 1, 8'hff, 2'd0);
        pix("bg_only_b", 5, 1, 8'hff, 2'd0);

        wait_cnt(10, 5);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {vga_red, vga_green, vga_blue}, 0);
        chk("mid_rst_sync", {vga_hsync, vga_vsync}, 2'b11);
        chk("mid_rst_hv", {bus.hcount, bus.vcount}, 0);
        chk("mid_rst_fs", bus.frame_start, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_rel_fs", bus.frame_start, 1);
        chk("mid_rel_hv", {bus.hcount, bus.vcount}, 0);
        @(posedge clock);
        #1;
        chk("mid_rel_h1", bus.hcount, 1);
        @(posedge clock);
        #1;
        chk("mid_rel_pix", {vga_red, vga_green, vga_blue}, 8'hff);
        chk("mid_rel_al", active_layer, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_layer_scheduler.md
Name: vga_layer_scheduler

Overview:
Sequences the 640x480 display pipeline and shares the single VGA output between NUM_LAYERS pixel-layer generators. It produces the hcount/vcount/enable stream that every layer module consumes and collects each layer's registered RGB332 pixel and `layer` claim flag. It selects the winning layer per pixel, applies blanking, and drives delay-matched hsync/vsync to the pins. Layer 0 is always the background, whose `layer` output is tied 0.

Parameters:
NUM_LAYERS, 4, number of layer inputs; index 0 is background, index NUM_LAYERS-1 is the highest priority.
H_ACTIVE, 640, visible pixels per line.
H_FP, 16, horizontal front porch.
H_SYNC, 96, hsync pulse width.
H_BP, 48, horizontal back porch.
V_ACTIVE, 480, visible lines.
V_FP, 10, vertical front porch.
V_SYNC, 2, vsync pulse width.
V_BP, 33, vertical back porch.
LAYER_LAT, 1, register latency of every layer module from hcount/vcount to its pixel output.

Ports:
clock  in  1  pixel clock (25.175 MHz nominal).
reset_n  in  1  asynchronous active-low reset.
layer_en_mask  in  NUM_LAYERS  per-layer enable; sampled at frame start only.
hcount  out  10  horizontal counter to layers.
vcount  out  10  vertical counter to layers.
enable  out  1  high in the active region (hcount<H_ACTIVE and vcount<V_ACTIVE).
frame_start  out  1  one-cycle pulse when hcount=0 and vcount=0.
layer_red  in  3*NUM_LAYERS  packed red per layer, layer i at [3i+2:3i].
layer_green  in  3*NUM_LAYERS  packed green per layer.
layer_blue  in  2*NUM_LAYERS  packed blue per layer.
layer_valid  in  NUM_LAYERS  per-layer `layer` claim flag; bit 0 ignored.
vga_red  out  3  composited red.
vga_green  out  3  composited green.
vga_blue  out  2  composited blue.
vga_hsync  out  1  active-low hsync.
vga_vsync  out  1  active-low vsync.
active_layer  out  clog2(NUM_LAYERS)  index of the winning layer for the current output pixel; 0 when blanked.

Behaviour:
- Reset (async assert, sync deassert on clock):
  - hcount=0, vcount=0.
  - enable=0 during reset, then combinational from the counters.
  - frame_start=0.
  - vga_red/green/blue=0.
  - vga_hsync=1, vga_vsync=1.
  - active_layer=0.
  - Mask shadow = all ones.
  - All delay-pipe stages are cleared to inactive or black.
- Counters:
  - hcount increments every clock and wraps at H_TOTAL-1 (799) to 0.
  - vcount increments when hcount wraps, and wraps at V_TOTAL-1 (524) to 0.
- Stage S0 (counter cycle t):
  - Raw hsync is low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751].
  - Raw vsync is low for vcount in [490,491].
  - frame_start=1 exactly when hcount=0 and vcount=0.
  - In the same cycle the mask shadow loads layer_en_mask; it applies to all pixels of that frame.
  - Mid-frame mask changes have no effect until the next frame_start.
- Layer stage: layers present pixel data at t+LAYER_LAT. The scheduler delays `enable`, the raw syncs and the shadow mask by LAYER_LAT to align with that data.
- Stage S2 (output register, t+LAYER_LAT+1):
  - Winner = highest i>=1 with layer_valid[i]=1 and shadow_mask[i]=1.
  - Otherwise winner = 0 if shadow_mask[0]=1.
  - Otherwise the pixel is black with active_layer=0.
  - If the delayed enable is 0, force RGB=0 and active_layer=0, regardless of layer data (layers hold stale values outside the active area).
  - vga_hsync/vga_vsync are the delayed raw syncs, registered in S2.
  - Total latency from counters to pins is LAYER_LAT+1 = 2 clocks, identical for RGB and syncs.
- Simultaneous claims: the strict fixed priority above applies; no round-robin; the result is stable per pixel.
- Reset mid-frame: the counters restart at 0,0. The first frame_start pulse occurs on the first clock after reset deassertion, when hcount=0 and vcount=0.

Decomposition:
- Package vga_pkg:
  - H_*/V_* timing constants.
  - H_TOTAL=800, V_TOTAL=525.
  - RGB332 field widths.
  - Packed rgb332 typedef.
  - clog2 helper.
- Sub-module vga_timing_gen: counters, enable, raw syncs and frame_start.
- The scheduler instantiates vga_timing_gen and adds mask shadowing, alignment delays and the priority composite.

Test Plan:
- Release reset, run 2 frames -> hsync low for 96 clocks per 800-clock line, starting 656+2 clocks after hcount=0. vsync low for 2 lines (1600 clocks) per 525 lines. frame_start period is 420000 clocks.
- Background only (layer 0 drives 3'b111/3'b111/2'b11, all layer_valid=0) -> vga RGB = 111/111/11 in the active area, 0 when enable is delayed low. active_layer=0.
- Layer 1 and layer 3 both valid at the same pixel (L1=red 3'b100, L3=blue 2'b01), mask=4'b1111 -> output 000/000/01, active_layer=3.
- Mask changed to 4'b0111 mid-frame at vcount=100 -> L3 still wins until the next frame_start. From then on, output = L1 data, active_layer=1.
- Mask 4'b0000, all layers valid -> output black and active_layer=0 for the whole frame. Syncs are unaffected.
- Assert reset_n=0 at hcount=300, vcount=200 for 3 clocks -> outputs immediately black, syncs =1. After release, hcount counts from 0 and frame_start pulses when hcount=0 and vcount=0.
